sad_min_tracker: RTL and testbench

//  Pipelined successor of the 16-way SAD compare stage. Finds the minimum
//  SAD among N_CAND candidates per beat (one search row). Tracks the running

---
 rtl/fsbm_pkg.sv | 26 ++
 rtl/sad_min_stage.sv | 63 ++++++
 rtl/sad_min_tracker.sv | 181 ++++++++++++++++++
 tb/tb_sad_min_tracker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsbm_pkg.sv
// Package: fsbm_pkg
// Shared definitions for the full-search block-matching datapath (PE array,
// SAD minimum tracker, motion-vector writer).
//  - default SAD / x / y field widths
//  - width and bit offsets of the {sad, x, y} result word
//  - tracker state encoding
package fsbm_pkg;

    localparam int N_CAND_DEF = 16;
    localparam int SAD_W_DEF  = 12;
    localparam int X_W_DEF    = 4;
    localparam int Y_W_DEF    = 4;

    localparam int RES_W = SAD_W_DEF + X_W_DEF + Y_W_DEF;

    // Result word layout, LSB first: y, then x, then sad.
    localparam int RES_Y_LSB   = 0;
    localparam int RES_X_LSB   = Y_W_DEF;
    localparam int RES_SAD_LSB = X_W_DEF + Y_W_DEF;

    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_ACC  = 1'b1
    } trk_state_t;

endpackage

// File: rtl/sad_min_stage.sv
// Module: sad_min_stage
// One registered level of the SAD minimum tree. Reduces 2*PAIRS {sad, x}
// entries to PAIRS winners; entry 2j competes with entry 2j+1.
// Ports:
//  clk, rst_n            clock, async active-low reset
//  clear                 sync flush of the valid flag
//  beat_valid/first/last sideband of the incoming beat
//  beat_y                row index of the incoming beat
//  pair_sad, pair_x      2*PAIRS packed SADs and x indices
//  win_*                 registered winners plus delayed sideband
module sad_min_stage
    import fsbm_pkg::*;
#(
    parameter int PAIRS = 8,
    parameter int SAD_W = SAD_W_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     beat_valid,
    input  logic                     beat_first,
    input  logic                     beat_last,
    input  logic [Y_W-1:0]           beat_y,
    input  logic [2*PAIRS*SAD_W-1:0] pair_sad,
    input  logic [2*PAIRS*X_W-1:0]   pair_x,
    output logic                     win_valid,
    output logic                     win_first,
    output logic                     win_last,
    output logic [Y_W-1:0]           win_y,
    output logic [PAIRS*SAD_W-1:0]   win_sad,
    output logic [PAIRS*X_W-1:0]     win_x
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            win_y     <= '0;
            win_sad   <= '0;
            win_x     <= '0;
        end else begin
            win_valid <= beat_valid && !clear;
            win_first <= beat_first;
            win_last  <= beat_last;
            win_y     <= beat_y;
            for (int j = 0; j < PAIRS; j++) begin
                // Entry 2j always covers lower x than entry 2j+1, so "<="
                // resolves equal SADs toward the lower x.
                if (pair_sad[2*j*SAD_W +: SAD_W] <= pair_sad[(2*j+1)*SAD_W +: SAD_W]) begin
                    win_sad[j*SAD_W +: SAD_W] <= pair_sad[2*j*SAD_W +: SAD_W];
                    win_x[j*X_W +: X_W]       <= pair_x[2*j*X_W +: X_W];
                end else begin
                    win_sad[j*SAD_W +: SAD_W] <= pair_sad[(2*j+1)*SAD_W +: SAD_W];
                    win_x[j*X_W +: X_W]       <= pair_x[(2*j+1)*X_W +: X_W];
                end
            end
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Module: sad_min_tracker
// Finds the minimum SAD over N_CAND candidates per row beat through a
// registered compare tree, then tracks the running minimum across the rows
// of a search window and emits one {sad, x, y} best match per window.
// Ports:
//  clk, rst_n        clock, async active-low reset
//  clear             sync flush of pipeline, window and result
//  in_valid          row beat valid (always accepted)
//  in_first/in_last  beat opens / closes a window
//  in_y              row index of the beat
//  sad_in            candidate i at [i*SAD_W +: SAD_W]
//  thresh            early-accept threshold, sampled when a result loads
//  out_valid/ready   result handshake: consumed when both are high
//  out_data          {sad, x, y}
//  out_hit           result sad < thresh
//  err_ovf           sticky: an unconsumed result was overwritten
module sad_min_tracker
    import fsbm_pkg::*;
#(
    parameter int N_CAND = N_CAND_DEF,
    parameter int SAD_W  = SAD_W_DEF,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic [Y_W-1:0]             in_y,
    input  logic [N_CAND*SAD_W-1:0]    sad_in,
    input  logic [SAD_W-1:0]           thresh,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAD_W+X_W+Y_W-1:0]   out_data,
    output logic                       out_hit,
    output logic                       err_ovf
);

    localparam int LEVELS = $clog2(N_CAND);

    // Candidate x index travels with its SAD through the tree.
    logic [N_CAND*X_W-1:0] x_init;
    for (genvar i = 0; i < N_CAND; i++) begin : g_xinit
        assign x_init[i*X_W +: X_W] = X_W'(i);
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int PAIRS = N_CAND >> (l + 1);
        logic [2*PAIRS*SAD_W-1:0] pair_sad;
        logic [2*PAIRS*X_W-1:0]   pair_x;
        logic                     beat_valid, beat_first, beat_last;
        logic [Y_W-1:0]           beat_y;
        logic [PAIRS*SAD_W-1:0]   win_sad;
        logic [PAIRS*X_W-1:0]     win_x;
        logic                     win_valid, win_first, win_last;
        logic [Y_W-1:0]           win_y;

        if (l == 0) begin : g_head
            assign pair_sad   = sad_in;
            assign pair_x     = x_init;
            assign beat_valid = in_valid;
            assign beat_first = in_first;
            assign beat_last  = in_last;
            assign beat_y     = in_y;
        end else begin : g_body
            assign pair_sad   = g_lvl[l-1].win_sad;
            assign pair_x     = g_lvl[l-1].win_x;
            assign beat_valid = g_lvl[l-1].win_valid;
            assign beat_first = g_lvl[l-1].win_first;
            assign beat_last  = g_lvl[l-1].win_last;
            assign beat_y     = g_lvl[l-1].win_y;
        end

        sad_min_stage #(
            .PAIRS (PAIRS),
            .SAD_W (SAD_W),
            .X_W   (X_W),
            .Y_W   (Y_W)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .beat_valid (beat_valid),
            .beat_first (beat_first),
            .beat_last  (beat_last),
            .beat_y     (beat_y),
            .pair_sad   (pair_sad),
            .pair_x     (pair_x),
            .win_valid  (win_valid),
            .win_first  (win_first),
            .win_last   (win_last),
            .win_y      (win_y),
            .win_sad    (win_sad),
            .win_x      (win_x)
        );
    end

    // Row winner at the tree output.
    logic [SAD_W-1:0] t_sad;
    logic [X_W-1:0]   t_x;
    logic [Y_W-1:0]   t_y;
    logic             t_valid, t_first, t_last;

    assign t_sad   = g_lvl[LEVELS-1].win_sad;
    assign t_x     = g_lvl[LEVELS-1].win_x;
    assign t_y     = g_lvl[LEVELS-1].win_y;
    assign t_valid = g_lvl[LEVELS-1].win_valid;
    assign t_first = g_lvl[LEVELS-1].win_first;
    assign t_last  = g_lvl[LEVELS-1].win_last;

    trk_state_t       state;
    logic [SAD_W-1:0] run_sad, res_sad;
    logic [X_W-1:0]   run_x, res_x;
    logic [Y_W-1:0]   run_y, res_y;

    logic             take, load, keep_run;
    logic [SAD_W-1:0] cand_sad;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;

    // A beat opening a window always reloads; inside a window the running
    // min survives unless the new row is strictly smaller (earlier row wins
    // ties). Beats outside a window that do not open one are dropped.
    always_comb begin
        take     = t_valid && (t_first || state == TRK_ACC);
        load     = take && t_last;
        keep_run = (state == TRK_ACC) && !t_first && !(t_sad < run_sad);
        cand_sad = keep_run ? run_sad : t_sad;
        cand_x   = keep_run ? run_x   : t_x;
        cand_y   = keep_run ? run_y   : t_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TRK_IDLE;
            run_sad   <= '0;
            run_x     <= '0;
            run_y     <= '0;
            res_sad   <= '0;
            res_x     <= '0;
            res_y     <= '0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= TRK_IDLE;
            out_valid <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            if (take) begin
                if (t_last) begin
                    state <= TRK_IDLE;
                end else begin
                    state   <= TRK_ACC;
                    run_sad <= cand_sad;
                    run_x   <= cand_x;
                    run_y   <= cand_y;
                end
            end
            // A load beats a same-cycle handshake; overwriting an unconsumed
            // result is the only way to lose one.
            if (load) begin
                res_sad   <= cand_sad;
                res_x     <= cand_x;
                res_y     <= cand_y;
                out_hit   <= cand_sad < thresh;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    err_ovf <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_data = {res_sad, res_x, res_y};

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker: directed vector table, multi-cycle corner
// sequences, a 64-candidate instance, and a randomized run checked against a
// transaction-level model of row minima and window minima.
module tb_sad_min_tracker;
  import fsbm_pkg::*;

  localparam int N    = 16;
  localparam int SW   = 12;
  localparam int LVLS = 4;
  localparam int N64  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clear;
  logic              in_valid, in_first, in_last;
  logic [3:0]        in_y;
  logic [N*SW-1:0]   sad_in;
  logic [11:0]       thresh;
  logic              out_ready, out_valid, out_hit, err_ovf;
  logic [19:0]       out_data;

  logic              in_valid_w, in_first_w, in_last_w;
  logic [3:0]        in_y_w;
  logic [N64*SW-1:0] sad_w;
  logic              out_ready_w, out_valid_w, out_hit_w, err_ovf_w;
  logic [21:0]       out_data_w;

  sad_min_tracker dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .in_y(in_y), .sad_in(sad_in),
    .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hit(out_hit), .err_ovf(err_ovf)
  );

  sad_min_tracker #(.N_CAND(64), .SAD_W(12), .X_W(6), .Y_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid_w),
    .in_first(in_first_w), .in_last(in_last_w), .in_y(in_y_w), .sad_in(sad_w),
    .thresh(thresh), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_data(out_data_w), .out_hit(out_hit_w), .err_ovf(err_ovf_w)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each beat is reduced to its row minimum when it enters; it takes effect
  // LVLS edges later. Windows keep the earliest strictly-smallest row.
  typedef struct {
    int         due;
    logic [11:0] sad;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        first;
    logic        last;
  } mbeat_t;

  mbeat_t      pend_q[$];
  int          edge_n = 0;
  bit          in_win = 0;
  mbeat_t      best;
  bit          exp_valid = 0;
  logic [19:0] exp_data = '0;
  bit          exp_hit = 0;
  bit          exp_err = 0;

  task automatic model_flush();
    pend_q.delete();
    in_win    = 0;
    exp_valid = 0;
    exp_err   = 0;
    exp_hit   = 0;
    exp_data  = '0;
  endtask

  task automatic model_step();
    mbeat_t b;
    bit load;
    load = 0;
    edge_n++;
    if (clear) begin
      pend_q.delete();
      in_win    = 0;
      exp_valid = 0;
      exp_err   = 0;
      return;
    end
    if (in_valid) begin
      b.due = edge_n + LVLS; b.y = in_y; b.first = in_first; b.last = in_last;
      b.sad = sad_in[11:0]; b.x = 4'd0;
      for (int i = 1; i < N; i++) begin
        if (sad_in[i*SW +: SW] < b.sad) begin
          b.sad = sad_in[i*SW +: SW];
          b.x   = 4'(i);
        end
      end
      pend_q.push_back(b);
    end
    if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
      b = pend_q.pop_front();
      if (b.first) begin
        best   = b;
        in_win = !b.last;
        load   = b.last;
      end else if (in_win) begin
        if (b.sad < best.sad) best = b;
        if (b.last) begin
          load   = 1;
          in_win = 0;
        end
      end
    end
    if (load) begin
      if (exp_valid && !out_ready) exp_err = 1;
      exp_valid = 1;
      exp_data  = {best.sad, best.x, best.y};
      exp_hit   = (best.sad < thresh);
    end else if (exp_valid && out_ready) begin
      exp_valid = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_flush();
      else model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N*SW-1:0] all_v(input logic [11:0] v);
    logic [N*SW-1:0] r;
    for (int i = 0; i < N; i++) r[i*SW +: SW] = v;
    return r;
  endfunction

  function automatic logic [N*SW-1:0] ramp16();
    logic [N*SW-1:0] r;
    for (int i = 0; i < N; i++) r[i*SW +: SW] = 12'(i*10 + 5);
    return r;
  endfunction

  task automatic beat(input logic f, input logic l, input logic [3:0] y, input logic [N*SW-1:0] s);
    in_valid = 1'b1; in_first = f; in_last = l; in_y = y; sad_in = s;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [N*SW-1:0] sads;
    logic [3:0]      y;
    logic [11:0]     thresh;
    logic [19:0]     exp_data;
    logic            exp_hit;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [N*SW-1:0]   v;
    logic [N64*SW-1:0] v64;

    // vector table: single-row windows
    v = ramp16(); v[9*SW +: SW] = 12'd3;
    tbl[0] = '{v, 4'd2, 12'd0, {12'd3, 4'd9, 4'd2}, 1'b0};
    v = all_v(12'd100); v[4*SW +: SW] = 12'd7; v[11*SW +: SW] = 12'd7;
    tbl[1] = '{v, 4'd5, 12'd8, {12'd7, 4'd4, 4'd5}, 1'b1};
    v = all_v(12'd100); v[6*SW +: SW] = 12'd49;
    tbl[2] = '{v, 4'd7, 12'd50, {12'd49, 4'd6, 4'd7}, 1'b1};
    tbl[3] = '{v, 4'd7, 12'd49, {12'd49, 4'd6, 4'd7}, 1'b0};
    tbl[4] = '{all_v(12'd60), 4'd15, 12'd61, {12'd60, 4'd0, 4'd15}, 1'b1};
    v = all_v(12'd4095); v[15*SW +: SW] = 12'd4094;
    tbl[5] = '{v, 4'd0, 12'd4095, {12'd4094, 4'd15, 4'd0}, 1'b1};
    v = all_v(12'd9); v[0 +: SW] = 12'd0;
    tbl[6] = '{v, 4'd9, 12'd0, {12'd0, 4'd0, 4'd9}, 1'b0};

    rst_n = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_y = '0; sad_in = '0;
    thresh = '0; out_ready = 1'b0;
    in_valid_w = 1'b0; in_first_w = 1'b0; in_last_w = 1'b0; in_y_w = '0; sad_w = '0;
    out_ready_w = 1'b0;
    idle(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_hit", out_hit, 0);
    chk("rst_err", err_ovf, 0);
    rst_n = 1'b1;
    idle(1);

    // table: latency, value, hit, handshake
    for (int k = 0; k < 7; k++) begin
      thresh = tbl[k].thresh;
      beat(1'b1, 1'b1, tbl[k].y, tbl[k].sads);
      idle(3);
      chk($sformatf("tbl%0d_early", k), out_valid, 0);
      idle(1);
      chk($sformatf("tbl%0d_valid", k), out_valid, 1);
      chk($sformatf("tbl%0d_data", k), out_data, tbl[k].exp_data);
      chk($sformatf("tbl%0d_hit", k), out_hit, tbl[k].exp_hit);
      chk($sformatf("tbl%0d_err", k), err_ovf, 0);
      consume();
      chk($sformatf("tbl%0d_taken", k), out_valid, 0);
    end

    // two rows with equal minima: earlier row kept
    thresh = 12'd0;
    v = all_v(12'd100); v[4*SW +: SW] = 12'd7; v[11*SW +: SW] = 12'd7;
    beat(1'b1, 1'b0, 4'd1, v);
    beat(1'b0, 1'b1, 4'd3, v);
    idle(4);
    chk("tie_rows_valid", out_valid, 1);
    chk("tie_rows_data", out_data, {12'd7, 4'd4, 4'd1});
    consume();

    // four-row window, result held while out_ready is low
    v = all_v(12'd30); beat(1'b1, 1'b0, 4'd0, v);
    beat(1'b0, 1'b0, 4'd1, v);
    v[15*SW +: SW] = 12'd20; beat(1'b0, 1'b0, 4'd2, v);
    v = all_v(12'd30); v[0 +: SW] = 12'd20; beat(1'b0, 1'b1, 4'd3, v);
    idle(10);
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, {12'd20, 4'd15, 4'd2});
    consume();
    chk("hold_taken", out_valid, 0);

    // back-to-back windows, nobody consuming: overwrite + sticky error
    beat(1'b1, 1'b1, 4'd1, all_v(12'd40));
    beat(1'b1, 1'b1, 4'd2, all_v(12'd30));
    idle(5);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_data", out_data, {12'd30, 4'd0, 4'd2});
    chk("ovf_err", err_ovf, 1);
    clear = 1'b1; idle(1); clear = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_err", err_ovf, 0);
    // beat in flight when clear hits is lost
    beat(1'b1, 1'b1, 4'd3, all_v(12'd10));
    idle(1);
    clear = 1'b1; idle(1); clear = 1'b0;
    idle(5);
    chk("clr_flight", out_valid, 0);

    // handshake and load on the same edge: stays valid, no error
    out_ready = 1'b1;
    beat(1'b1, 1'b1, 4'd1, all_v(12'd50));
    beat(1'b1, 1'b1, 4'd2, all_v(12'd40));
    idle(4);
    chk("hs_load_valid", out_valid, 1);
    chk("hs_load_data", out_data, {12'd40, 4'd0, 4'd2});
    chk("hs_load_err", err_ovf, 0);
    idle(1);
    chk("hs_load_taken", out_valid, 0);
    out_ready = 1'b0;

    // async reset mid-window
    thresh = 12'd4095;
    v = ramp16(); v[9*SW +: SW] = 12'd3;
    beat(1'b1, 1'b1, 4'd3, v);
    beat(1'b1, 1'b1, 4'd4, v);
    idle(5);
    chk("pre_rst_err", err_ovf, 1);
    chk("pre_rst_hit", out_hit, 1);
    beat(1'b1, 1'b0, 4'd0, all_v(12'd1));
    idle(1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_hit", out_hit, 0);
    chk("arst_err", err_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1'b0, 1'b1, 4'd1, all_v(12'd1));
    idle(8);
    chk("no_first_valid", out_valid, 0);

    // 64-candidate instance: six tree levels
    thresh = 12'd0;
    for (int i = 0; i < N64; i++) v64[i*SW +: SW] = 12'(i*10 + 5);
    v64[9*SW +: SW] = 12'd3;
    in_valid_w = 1'b1; in_first_w = 1'b1; in_last_w = 1'b1; in_y_w = 4'd2; sad_w = v64;
    @(negedge clk);
    in_valid_w = 1'b0; in_first_w = 1'b0; in_last_w = 1'b0;
    idle(5);
    chk("n64_early", out_valid_w, 0);
    idle(1);
    chk("n64_valid", out_valid_w, 1);
    chk("n64_data", out_data_w, {12'd3, 6'd9, 4'd2});
    out_ready_w = 1'b1;
    for (int i = 0; i < N64; i++) v64[i*SW +: SW] = 12'd500;
    v64[40*SW +: SW] = 12'd1; v64[63*SW +: SW] = 12'd1;
    in_valid_w = 1'b1; in_first_w = 1'b1; in_last_w = 1'b1; in_y_w = 4'd6; sad_w = v64;
    @(negedge clk);
    in_valid_w = 1'b0; in_first_w = 1'b0; in_last_w = 1'b0;
    idle(6);
    chk("n64_tie_data", out_data_w, {12'd1, 6'd40, 4'd6});
    chk("n64_tie_err", err_ovf_w, 0);
    out_ready_w = 1'b0;

    // randomized traffic against the model
    clear = 1'b1; idle(1); clear = 1'b0;
    for (int c = 0; c < 600; c++) begin
      chk("rnd_valid", out_valid, exp_valid);
      chk("rnd_err", err_ovf, exp_err);
      if (exp_valid) begin
        chk("rnd_data", out_data, exp_data);
        chk("rnd_hit", out_hit, exp_hit);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_first  = ($urandom_range(0, 3) == 0);
      in_last   = ($urandom_range(0, 2) == 0);
      in_y      = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) sad_in[i*SW +: SW] = 12'($urandom_range(4000, 4095));
        else sad_in[i*SW +: SW] = 12'($urandom_range(0, 15));
      end
      thresh    = 12'($urandom_range(0, 16));
      out_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
